// File: rtl/cp0_regfile.sv
// MIPS coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, PRId.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise TI is tied low.
module cp0_regfile #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_0001,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cp_read_en,
    input  logic [4:0]  cp_read_addr,
    output logic [31:0] cp_read_data,
    input  logic        cp_write_en,
    input  logic [4:0]  cp_write_addr,
    input  logic [31:0] cp_write_data,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] status_out,
    output logic [31:0] cause_out,
    output logic [31:0] epc_out,
    output logic        int_pending
);

    localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
    localparam logic [4:0]  ADDR_COUNT    = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
    localparam logic [4:0]  ADDR_STATUS   = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
    localparam logic [4:0]  ADDR_EPC      = 5'd14;
    localparam logic [4:0]  ADDR_PRID     = 5'd15;
    localparam logic [31:0] STATUS_MASK   = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_MASK    = 32'h0000_0300;

    logic [31:0] badvaddr_q;
    logic [31:0] epc_q;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [4:0]  exc_code_q;
    logic [1:0]  sw_ip_q;
    logic [5:0]  hw_ip_q;
    logic        ti;
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic [7:0]  ip_all;
    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic [31:0] write_mask;
    logic        write_status;
    logic        write_cause;
    logic        write_epc;

    assign write_status = cp_write_en && (cp_write_addr == ADDR_STATUS);
    assign write_cause  = cp_write_en && (cp_write_addr == ADDR_CAUSE);
    assign write_epc    = cp_write_en && (cp_write_addr == ADDR_EPC);

`ifdef CP0_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        phase_q;
    logic        ti_q;
    logic        write_count;
    logic        write_compare;

    assign write_count   = cp_write_en && (cp_write_addr == ADDR_COUNT);
    assign write_compare = cp_write_en && (cp_write_addr == ADDR_COMPARE);

    // A Count write restarts the divider; a Compare write clears TI even if a match is seen that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            phase_q   <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            if (write_count) begin
                count_q <= cp_write_data;
                phase_q <= 1'b0;
            end else begin
                phase_q <= (COUNT_DIV == 1) ? 1'b0 : ~phase_q;
                if ((COUNT_DIV == 1) || phase_q)
                    count_q <= count_q + 32'd1;
            end
            if (write_compare) begin
                compare_q <= cp_write_data;
                ti_q      <= 1'b0;
            end else if (count_q == compare_q) begin
                ti_q <= 1'b1;
            end
        end
    end

    assign count_val   = count_q;
    assign compare_val = compare_q;
    assign ti          = ti_q;
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign ti          = 1'b0;
`endif

    // Exception outranks ERET, which outranks MTC0, on EXL; EPC is reserved for the exception path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            sw_ip_q    <= '0;
            hw_ip_q    <= '0;
        end else begin
            hw_ip_q <= hw_int;
            if (exc_valid) begin
                exl_q      <= 1'b1;
                exc_code_q <= exc_code;
                if (!exl_q) begin
                    epc_q <= exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
                    bd_q  <= exc_in_delay_slot;
                end
                if ((exc_code == 5'd4) || (exc_code == 5'd5))
                    badvaddr_q <= exc_badvaddr;
            end else if (eret) begin
                exl_q <= 1'b0;
            end else if (write_status) begin
                exl_q <= cp_write_data[1];
            end
            if (write_status) begin
                im_q <= cp_write_data[15:8];
                ie_q <= cp_write_data[0];
            end
            if (write_cause)
                sw_ip_q <= cp_write_data[9:8];
            if (write_epc && !exc_valid)
                epc_q <= cp_write_data;
        end
    end

    assign ip_all     = {hw_ip_q[5] | ti, hw_ip_q[4:0], sw_ip_q};
    assign status_val = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti, 14'd0, ip_all, 1'b0, exc_code_q, 2'b00};

    always_comb begin
        write_mask = '0;
        case (cp_write_addr)
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   write_mask = '1;
            ADDR_COMPARE: write_mask = '1;
`endif
            ADDR_STATUS:  write_mask = STATUS_MASK;
            ADDR_CAUSE:   write_mask = CAUSE_MASK;
            ADDR_EPC:     write_mask = '1;
            default:      write_mask = '0;
        endcase
    end

    // A write to the register being read is forwarded so MFC0 sees the post-write value.
    always_comb begin
        cp_read_data = '0;
        if (cp_read_en) begin
            case (cp_read_addr)
                ADDR_BADVADDR: cp_read_data = badvaddr_q;
                ADDR_COUNT:    cp_read_data = count_val;
                ADDR_COMPARE:  cp_read_data = compare_val;
                ADDR_STATUS:   cp_read_data = status_val;
                ADDR_CAUSE:    cp_read_data = cause_val;
                ADDR_EPC:      cp_read_data = epc_q;
                ADDR_PRID:     cp_read_data = PRID_VALUE;
                default:       cp_read_data = '0;
            endcase
            if (cp_write_en && (cp_write_addr == cp_read_addr))
                cp_read_data = (cp_read_data & ~write_mask) | (cp_write_data & write_mask);
        end
    end

    assign status_out  = status_val;
    assign cause_out   = cause_val;
    assign epc_out     = epc_q;
    assign int_pending = ie_q & ~exl_q & (|(ip_all & im_q));

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: spec-level register model plus directed vectors.
// Timer vectors run only when CP0_TIMER_EN is defined.
module tb_cp0_regfile;

    localparam logic [31:0] PRID      = 32'h0000_0001;
    localparam int          COUNT_DIV = 2;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cp_read_en;
    logic [4:0]  cp_read_addr;
    logic [31:0] cp_read_data;
    logic        cp_write_en;
    logic [4:0]  cp_write_addr;
    logic [31:0] cp_write_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] status_out;
    logic [31:0] cause_out;
    logic [31:0] epc_out;
    logic        int_pending;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    cp0_regfile #(.PRID_VALUE(PRID), .COUNT_DIV(COUNT_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .cp_read_en(cp_read_en), .cp_read_addr(cp_read_addr), .cp_read_data(cp_read_data),
        .cp_write_en(cp_write_en), .cp_write_addr(cp_write_addr), .cp_write_data(cp_write_data),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_in_delay_slot(exc_in_delay_slot), .exc_badvaddr(exc_badvaddr), .eret(eret),
        .hw_int(hw_int), .status_out(status_out), .cause_out(cause_out), .epc_out(epc_out),
        .int_pending(int_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, kept as whole architectural register values and fields
    logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
    logic        m_bd, m_ti;
    logic [4:0]  m_code;
    logic [1:0]  m_swip;
    logic [5:0]  m_hwip;
    int          m_half;
    logic [31:0] n_status, n_epc, n_badv, n_count, n_compare;
    logic        n_bd, n_ti;
    logic [4:0]  n_code;
    logic [1:0]  n_swip;
    int          n_half;

    function automatic logic [31:0] exp_cause();
        logic [31:0] c;
        c = (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_hwip[5] | m_ti) << 15)
          | (32'(m_hwip[4:0]) << 10) | (32'(m_swip) << 8) | (32'(m_code) << 2);
        return c;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return TIMER ? m_count : 32'd0;
            5'd11:   return TIMER ? m_compare : 32'd0;
            5'd12:   return m_status;
            5'd13:   return exp_cause();
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] wmask(input logic [4:0] a);
        case (a)
            5'd9, 5'd11: return TIMER ? 32'hFFFF_FFFF : 32'd0;
            5'd12:       return 32'h0000_FF03;
            5'd13:       return 32'h0000_0300;
            5'd14:       return 32'hFFFF_FFFF;
            default:     return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_read();
        logic [31:0] v;
        if (!cp_read_en) return 32'd0;
        v = exp_reg(cp_read_addr);
        if (cp_write_en && cp_write_addr == cp_read_addr)
            v = (v & ~wmask(cp_read_addr)) | (cp_write_data & wmask(cp_read_addr));
        return v;
    endfunction

    function automatic logic exp_int();
        logic [31:0] c;
        c = exp_cause();
        return m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
    endfunction

    // Apply events lowest priority first so higher-priority events overwrite shared fields
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
            m_bd = 0; m_ti = 0; m_code = 0; m_swip = 0; m_hwip = 0; m_half = 0;
        end else begin
            n_status = m_status; n_epc = m_epc; n_badv = m_badv; n_count = m_count;
            n_compare = m_compare; n_bd = m_bd; n_ti = m_ti; n_code = m_code;
            n_swip = m_swip; n_half = m_half;
            if (cp_write_en) begin
                case (cp_write_addr)
                    5'd12: n_status = (m_status & ~32'h0000_FF03) | (cp_write_data & 32'h0000_FF03);
                    5'd13: n_swip = cp_write_data[9:8];
                    5'd14: n_epc = cp_write_data;
                    5'd9:  if (TIMER) n_count = cp_write_data;
                    5'd11: if (TIMER) n_compare = cp_write_data;
                    default: ;
                endcase
            end
            if (TIMER) begin
                if (cp_write_en && cp_write_addr == 5'd9) begin
                    n_half = 0;
                end else begin
                    n_half = m_half + 1;
                    if (n_half == COUNT_DIV) begin
                        n_count = m_count + 32'd1;
                        n_half  = 0;
                    end
                end
                if (cp_write_en && cp_write_addr == 5'd11) n_ti = 1'b0;
                else if (m_count == m_compare) n_ti = 1'b1;
            end
            if (eret) n_status[1] = 1'b0;
            if (exc_valid) begin
                n_status[1] = 1'b1;
                n_code = exc_code;
                n_epc = m_epc;
                if (!m_status[1]) begin
                    n_epc = exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
                    n_bd  = exc_in_delay_slot;
                end
                if (exc_code == 5'd4 || exc_code == 5'd5) n_badv = exc_badvaddr;
            end
            m_status = n_status; m_epc = n_epc; m_badv = n_badv; m_count = n_count;
            m_compare = n_compare; m_bd = n_bd; m_ti = n_ti; m_code = n_code;
            m_swip = n_swip; m_half = n_half; m_hwip = hw_int;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            checkOutput("model_status", status_out, m_status);
            checkOutput("model_cause", cause_out, exp_cause());
            checkOutput("model_epc", epc_out, m_epc);
            checkOutput("model_int", 32'(int_pending), 32'(exp_int()));
            checkOutput("model_read", cp_read_data, exp_read());
        end
    end

    task automatic applyStimulus(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic exc, input logic [4:0] code, input logic [31:0] pc,
                                 input logic ds, input logic [31:0] bva, input logic er);
        cp_write_en = wen; cp_write_addr = wa; cp_write_data = wd;
        exc_valid = exc; exc_code = code; exc_pc = pc; exc_in_delay_slot = ds;
        exc_badvaddr = bva; eret = er;
        @(posedge clk);
        #1;
        cp_write_en = 1'b0; exc_valid = 1'b0; eret = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic readCheck(input string name, input logic [4:0] a, input logic [31:0] exp);
        cp_read_en = 1'b1; cp_read_addr = a;
        #1;
        checkOutput(name, cp_read_data, exp);
        cp_read_en = 1'b0;
    endtask

    initial begin
        cp_read_en = 0; cp_read_addr = 0; cp_write_en = 0; cp_write_addr = 0; cp_write_data = 0;
        exc_valid = 0; exc_code = 0; exc_pc = 0; exc_in_delay_slot = 0; exc_badvaddr = 0;
        eret = 0; hw_int = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_status", status_out, 32'h0040_0000);
        checkOutput("rst_cause", cause_out, 32'd0);
        checkOutput("rst_epc", epc_out, 32'd0);
        checkOutput("rst_int", 32'(int_pending), 32'd0);
        checkOutput("rst_read", cp_read_data, 32'd0);
        #3 rst_n = 1'b1;
        readCheck("read_status", 5'd12, 32'h0040_0000);
        readCheck("read_cause", 5'd13, 32'd0);
        readCheck("read_prid", 5'd15, PRID);
        cmp_en = 1'b1;

        // Status write with same-cycle bypass
        cp_write_en = 1'b1; cp_write_addr = 5'd12; cp_write_data = 32'hFFFF_FFFF;
        readCheck("bypass_status", 5'd12, 32'h0040_FF03);
        @(posedge clk);
        #1;
        cp_write_en = 1'b0;
        readCheck("status_wr", 5'd12, 32'h0040_FF03);
        readCheck("unimpl_addr", 5'd3, 32'd0);

        // Exceptions and ERET
        mtc0(5'd12, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_1008, 1'b1, 32'h0000_0003, 1'b0);
        checkOutput("exc_epc", epc_out, 32'h0000_1004);
        checkOutput("exc_cause", cause_out & 32'hBFFF_7FFF, 32'h8000_0010);
        checkOutput("exc_status", status_out, 32'h0040_0002);
        readCheck("exc_badv", 5'd8, 32'h0000_0003);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h0000_2000, 1'b0, 32'h0000_0FF0, 1'b0);
        checkOutput("exc2_epc", epc_out, 32'h0000_1004);
        checkOutput("exc2_cause", cause_out & 32'hBFFF_7FFF, 32'h8000_0020);
        readCheck("exc2_badv", 5'd8, 32'h0000_0003);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("eret_status", status_out, 32'h0040_0000);

        // Interrupt masking
        hw_int = 6'b000001;
        mtc0(5'd12, 32'h0000_0401);
        checkOutput("ip10", 32'(cause_out[10]), 32'd1);
        checkOutput("int_on", 32'(int_pending), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_3000, 1'b0, 32'd0, 1'b0);
        checkOutput("int_exl", 32'(int_pending), 32'd0);
        checkOutput("int_epc", epc_out, 32'h0000_3000);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("int_eret", 32'(int_pending), 32'd1);
        mtc0(5'd13, 32'h0000_0300);
        readCheck("cause_sw", 5'd13, {cause_out[31:16], 6'b000001, 2'b11, cause_out[7:0]});
        hw_int = 6'd0;
        tickN(1);
        checkOutput("int_off", 32'(int_pending), 32'd0);
        mtc0(5'd13, 32'd0);

`ifdef CP0_TIMER_EN
        mtc0(5'd9, 32'h0000_1000);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        tickN(10);
        readCheck("count_5", 5'd9, 32'd5);
        checkOutput("ti_early", 32'(cause_out[30]), 32'd0);
        tickN(1);
        checkOutput("ti_set", 32'(cause_out[30]), 32'd1);
        mtc0(5'd11, 32'd9);
        checkOutput("ti_clear", 32'(cause_out[30]), 32'd0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        tickN(2);
        readCheck("count_wrap", 5'd9, 32'd0);
`else
        mtc0(5'd9, 32'h0000_1234);
        readCheck("count_absent", 5'd9, 32'd0);
`endif

        // Same-cycle priority
        applyStimulus(1'b1, 5'd14, 32'h0000_1234, 1'b1, 5'd13, 32'h0000_0400, 1'b0, 32'd0, 1'b1);
        checkOutput("prio_epc", epc_out, 32'h0000_0400);
        checkOutput("prio_exl", 32'(status_out[1]), 32'd1);
        applyStimulus(1'b1, 5'd12, 32'h0000_FF00, 1'b1, 5'd2, 32'h0000_0500, 1'b0, 32'd0, 1'b0);
        checkOutput("prio_status_exc", status_out, 32'h0040_FF02);
        checkOutput("prio_epc_hold", epc_out, 32'h0000_0400);
        applyStimulus(1'b1, 5'd12, 32'h0000_0003, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("prio_status_eret", status_out, 32'h0040_0001);

        // Reset in the middle of a pending write and exception
        cp_write_en = 1'b1; cp_write_addr = 5'd14; cp_write_data = 32'h0000_DEAD;
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_0800; exc_badvaddr = 32'h0000_BEEF;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_epc", epc_out, 32'd0);
        checkOutput("mid_rst_status", status_out, 32'h0040_0000);
        checkOutput("mid_rst_cause", cause_out, 32'd0);
        @(posedge clk);
        #1;
        cp_write_en = 1'b0; exc_valid = 1'b0;
        rst_n = 1'b1;
        readCheck("mid_rst_badv", 5'd8, 32'd0);
        readCheck("mid_rst_epc_rd", 5'd14, 32'd0);
        tickN(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file for the MIPS core.
- Consumes the CP0 read/write enables and addresses that ID-stage register-address generation produces for MFC0/MTC0.
- Serves MFC0 reads to ID and takes MTC0 writes from the write-back path.
- Holds exception state (Status/Cause/EPC/BadVAddr), runs the Count/Compare timer, and raises the interrupt request to the exception unit.

Parameters:
- PRID_VALUE, 32'h0000_0001, constant returned for PRId (reg 15).
- COUNT_DIV, 2, core cycles per Count increment; legal values 1 or 2.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cp_read_en  in  1  MFC0 read enable.
- cp_read_addr  in  5  CP0 register number to read.
- cp_read_data  out  32  read data; 0 when cp_read_en=0 or address unimplemented.
- cp_write_en  in  1  MTC0 write enable.
- cp_write_addr  in  5  CP0 register number to write.
- cp_write_data  in  32  MTC0 data.
- exc_valid  in  1  exception commit strobe, one cycle.
- exc_code  in  5  ExcCode to record.
- exc_pc  in  32  PC of the faulting instruction.
- exc_in_delay_slot  in  1  faulting instruction is in a branch delay slot.
- exc_badvaddr  in  32  faulting address for AdEL/AdES.
- eret  in  1  ERET commit strobe.
- hw_int  in  6  external interrupt lines, level, already synchronous to clk.
- status_out  out  32  current Status.
- cause_out  out  32  current Cause.
- epc_out  out  32  current EPC; used as the ERET target.
- int_pending  out  1  interrupt request to the exception unit.

Behaviour:
- Implemented registers:
  - 8 BadVAddr: read-only to software.
  - 9 Count: read/write.
  - 11 Compare: read/write.
  - 12 Status: writable bits IM[15:8], EXL[1], IE[0]; BEV[22] reads 1; all other bits read 0.
  - 13 Cause: writable bits IP[9:8] only; BD[31], TI[30], IP[15:10], ExcCode[6:2] are hardware-owned.
  - 14 EPC: read/write.
  - 15 PRId: constant.
  - All other addresses: read 0, writes ignored.
- Reset (async, rst_n low):
  - Status = 32'h0040_0000; Cause, EPC, BadVAddr, Count, Compare = 0; divider phase = 0.
  - Outputs follow: cp_read_data=0, status_out=32'h0040_0000, cause_out=0, epc_out=0, int_pending=0.
- Read is combinational, zero latency.
  - Same-cycle bypass: if cp_write_en, cp_write_addr==cp_read_addr and the register is writable, cp_read_data returns the post-write value (write data merged under the write mask).
- Writes take effect at the next rising edge.
- Same-cycle priority:
  - exc_valid beats eret, and eret beats MTC0 for the fields each one touches (Status.EXL, Cause.BD/ExcCode, EPC, BadVAddr).
  - MTC0 to fields the higher-priority event does not touch still completes.
- Exception, on exc_valid:
  - Cause.ExcCode <= exc_code; Status.EXL <= 1.
  - If Status.EXL was 0: EPC <= exc_in_delay_slot ? exc_pc-4 : exc_pc (32-bit wrap), and Cause.BD <= exc_in_delay_slot.
  - If EXL was already 1, EPC and BD hold.
  - If exc_code is 4 (AdEL) or 5 (AdES): BadVAddr <= exc_badvaddr.
- ERET: Status.EXL <= 0.
- Cause.IP[15:10] <= hw_int every cycle, registered, with IP[15] = hw_int[5] | TI.
- Count/Compare timer:
  - Divider phase toggles each cycle (COUNT_DIV=2); Count += 1 (mod 2^32) on the cycle where the phase is 1.
  - MTC0 to Count loads the value, clears the phase and suppresses that cycle's increment.
  - TI sets at the edge after Count==Compare (comparing registered values) and stays set.
  - MTC0 to Compare clears TI; the clear beats a same-cycle set.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]), combinational from registers.
- Reset asserted mid-operation discards any in-flight write or exception; no partial update survives.

Optional Feature:
- CP0_TIMER_EN.
- Defined: Count/Compare/TI behave as above.
- Undefined: Count and Compare registers are not built; reads return 0 and writes are ignored; TI is constant 0, so IP[15] = hw_int[5]; the Compare-write TI clear is a no-op.

Test Plan:
- Reset, then read addr 12, 13, 15 -> 32'h0040_0000, 0, PRID_VALUE; int_pending=0.
- MTC0 Status=32'hFFFF_FFFF, read back -> 32'h0040_FF03; same-cycle read of addr 12 during the write -> 32'h0040_FF03.
- exc_valid, code 4, exc_pc=32'h0000_1008, delay slot=1, badvaddr=32'h0000_0003 -> EPC=32'h0000_1004, Cause=32'h8000_0010, BadVAddr=3, EXL=1. A second exception with exc_pc=32'h2000 keeps EPC=32'h1004. eret -> EXL=0.
- Status=32'h0000_0401, hw_int=6'b000001 -> Cause.IP10=1 one cycle later, int_pending=1. Set EXL via exception -> int_pending=0.
- CP0_TIMER_EN, COUNT_DIV=2: Compare=5, Count=0 -> Count=5 after 10 cycles, TI=1 on the next edge, Cause[30]=1. MTC0 Compare=9 -> TI=0. Count=32'hFFFF_FFFF -> wraps to 0 two cycles later.
- Same cycle: exc_valid + eret + MTC0 EPC=32'h1234 with EXL=0, exc_pc=32'h400 -> EPC=32'h400, EXL=1.
